i2c_slave_regbank: RTL and testbench

- Parametrised I2C target that exposes a register bank of NUM_REGS × DATA_W-bit registers through a synchronous register port.
- Oversamples SCL/SDA on i_ck with a configurable glitch filter.
- Supports device-address match, register-pointer write, burst write and burst read with pointer auto-increment and wrap, repeated START, and NACK of out-of-range register addresses.
- Sits between the board-level open-drain pins and a register file or SRAM.

---
 rtl/i2c_slave_regbank.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// I2C target exposing NUM_REGS x DATA_W registers through a synchronous
// register port. SCL/SDA are oversampled on i_ck and glitch-filtered; the
// block only ever pulls SDA low and otherwise leaves it floating.
module i2c_slave_regbank #(
  parameter logic [6:0] DEV_ADDR = 7'h02,
  parameter int         NUM_REGS = 16,
  parameter int         REG_AW   = 4,
  parameter int         DATA_W   = 8,
  parameter int         FILT_LEN = 4
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              SCL,
  inout  wire               SDA,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  // Elaboration-time parameter checks
  if (DATA_W != 8) begin : g_bad_data_w
    $error("i2c_slave_regbank: DATA_W must be 8");
  end
  if ((NUM_REGS < 2) || (NUM_REGS > 256)) begin : g_bad_num_regs
    $error("i2c_slave_regbank: NUM_REGS must be in 2..256");
  end
  if ((REG_AW < 1) || (REG_AW > 8) || ((1 << REG_AW) < NUM_REGS)) begin : g_bad_reg_aw
    $error("i2c_slave_regbank: REG_AW must be 1..8 with 2**REG_AW >= NUM_REGS");
  end
  if ((FILT_LEN < 2) || (FILT_LEN > 8)) begin : g_bad_filt_len
    $error("i2c_slave_regbank: FILT_LEN must be in 2..8");
  end

  localparam logic [REG_AW-1:0] LAST_ADDR  = REG_AW'(NUM_REGS - 1);
  localparam logic [REG_AW-1:0] ONE_ADDR   = REG_AW'(1);
  localparam logic [8:0]        NUM_REGS_9 = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8
  } state_t;

  // Pointer increment that wraps from the last implemented register to 0
  function automatic logic [REG_AW-1:0] f_inc_wrap(input logic [REG_AW-1:0] a);
    if (a == LAST_ADDR) begin
      f_inc_wrap = '0;
    end else begin
      f_inc_wrap = a + ONE_ADDR;
    end
  endfunction

  // Filter and edge-detect state
  logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                r_sclf, r_sclf_d, r_sdaf, r_sdaf_d;

  // Protocol state
  state_t              r_state, w_state_nxt;
  logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic                r_ack_on, w_ack_on_nxt;
  logic                r_rw, w_rw_nxt;
  logic                r_sda_oe, w_sda_oe_nxt;
  logic [REG_AW-1:0]   r_addr, w_addr_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_busy, w_busy_nxt;

  // Read-data capture
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_rdata_lat;

  logic                w_sda_in;
  logic                w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]          w_byte;
  logic                w_ptr_ok;

  assign w_sda_in = SDA;
  assign SDA      = r_sda_oe ? 1'b0 : 1'bz;

  // Glitch filters: a line changes level only after FILT_LEN equal samples
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_sclf     <= 1'b1;
      r_sdaf     <= 1'b1;
      r_sclf_d   <= 1'b1;
      r_sdaf_d   <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[FILT_LEN-2:0], SCL};
      r_sda_hist <= {r_sda_hist[FILT_LEN-2:0], w_sda_in};
      if (&r_scl_hist) begin
        r_sclf <= 1'b1;
      end else if (~|r_scl_hist) begin
        r_sclf <= 1'b0;
      end
      if (&r_sda_hist) begin
        r_sdaf <= 1'b1;
      end else if (~|r_sda_hist) begin
        r_sdaf <= 1'b0;
      end
      r_sclf_d <= r_sclf;
      r_sdaf_d <= r_sdaf;
    end
  end

  assign w_scl_rise = r_sclf & ~r_sclf_d;
  assign w_scl_fall = ~r_sclf & r_sclf_d;
  assign w_start    = r_sclf & r_sclf_d & r_sdaf_d & ~r_sdaf;
  assign w_stop     = r_sclf & r_sclf_d & ~r_sdaf_d & r_sdaf;
  assign w_byte     = {r_shift[6:0], r_sdaf};
  assign w_ptr_ok   = ({1'b0, w_byte} < NUM_REGS_9);

  // Register-file read data is valid the cycle after the read strobe
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rd_pend   <= 1'b0;
      r_rdata_lat <= '0;
    end else begin
      r_rd_pend <= r_rd_en;
      if (r_rd_pend) begin
        r_rdata_lat <= reg_rdata;
      end
    end
  end

  // Protocol FSM state and datapath registers
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_ack_on  <= 1'b0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wdata   <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ack_on  <= w_ack_on_nxt;
      r_rw      <= w_rw_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; START/STOP override any SCL edge
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ack_on_nxt  = r_ack_on;
    w_rw_nxt      = r_rw;
    w_sda_oe_nxt  = r_sda_oe;
    w_addr_nxt    = r_addr;
    w_wr_en_nxt   = 1'b0;
    w_wdata_nxt   = r_wdata;
    w_rd_en_nxt   = 1'b0;
    w_busy_nxt    = r_busy;

    if (w_stop) begin
      w_state_nxt   = ST_IDLE;
      w_busy_nxt    = 1'b0;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = 3'd0;
      w_ack_on_nxt  = 1'b0;
    end else if (w_start) begin
      // pointer is kept so a repeated START + read continues from it
      w_state_nxt   = ST_ADDR;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = 3'd0;
      w_ack_on_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sda_oe_nxt = 1'b0;
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt = 3'd0;
              if (w_byte[7:1] == DEV_ADDR) begin
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = w_byte[0];
                w_rd_en_nxt = w_byte[0];
                w_state_nxt = ST_ADDR_ACK;
              end else begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_ack_on_nxt  = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              if (r_rw) begin
                w_shift_nxt  = r_rdata_lat;
                w_sda_oe_nxt = ~r_rdata_lat[7];
                w_state_nxt  = ST_RD;
              end else begin
                w_sda_oe_nxt = 1'b0;
                w_state_nxt  = ST_PTR;
              end
            end
          end else begin
            w_ack_on_nxt = r_ack_on;
          end
        end

        ST_PTR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt = 3'd0;
              if (w_ptr_ok) begin
                w_addr_nxt  = w_byte[REG_AW-1:0];
                w_state_nxt = ST_PTR_ACK;
              end else begin
                // out-of-range pointer: NACK by leaving SDA released
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end

        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt  = 1'b0;
              w_ack_on_nxt  = 1'b0;
              w_bit_cnt_nxt = 3'd0;
              w_state_nxt   = ST_WR;
            end
          end else begin
            w_ack_on_nxt = r_ack_on;
          end
        end

        ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            if (r_bit_cnt == 3'd7) begin
              w_bit_cnt_nxt = 3'd0;
              w_wdata_nxt   = w_byte;
              w_wr_en_nxt   = 1'b1;
              w_state_nxt   = ST_WR_ACK;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end

        ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_sda_oe_nxt = 1'b1;
              w_ack_on_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_ack_on_nxt = 1'b0;
              w_addr_nxt   = f_inc_wrap(r_addr);
              w_state_nxt  = ST_WR;
            end
          end else begin
            w_ack_on_nxt = r_ack_on;
          end
        end

        ST_RD: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              // byte done: prefetch the next register for a possible ACK
              w_bit_cnt_nxt = 3'd0;
              w_sda_oe_nxt  = 1'b0;
              w_addr_nxt    = f_inc_wrap(r_addr);
              w_rd_en_nxt   = 1'b1;
              w_state_nxt   = ST_RD_ACK;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt  = ~r_shift[6];
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!r_sdaf) begin
              w_ack_on_nxt = 1'b1;
            end else begin
              w_ack_on_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
              w_state_nxt  = ST_IDLE;
            end
          end else if (w_scl_fall && r_ack_on) begin
            w_ack_on_nxt  = 1'b0;
            w_bit_cnt_nxt = 3'd0;
            w_shift_nxt   = r_rdata_lat;
            w_sda_oe_nxt  = ~r_rdata_lat[7];
            w_state_nxt   = ST_RD;
          end else begin
            w_ack_on_nxt = r_ack_on;
          end
        end

        default: begin
          w_state_nxt  = ST_IDLE;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign reg_addr  = r_addr;
  assign reg_wr_en = r_wr_en;
  assign reg_wdata = r_wdata;
  assign reg_rd_en = r_rd_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: a bit-banged I2C master drives two targets on
// one open-drain bus (0x02 with 16 regs, 0x03 with 12 regs). Expected register
// writes and read bytes are queued when the stimulus is issued and compared
// when the target produces them.
module tb_i2c_slave_regbank;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  logic [3:0] addr1, addr2;
  logic       wr1, wr2, rd1, rd2, busy1, busy2;
  logic [7:0] wd1, wd2;
  logic [7:0] rdata1 = 8'h00;
  logic [7:0] rdata2 = 8'h00;
  logic [7:0] mem [16];

  int n_assert = 0;
  int n_fail   = 0;
  int n_wr1 = 0, n_rd1 = 0, n_wr2 = 0, n_overlap = 0;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  always #5 clk = ~clk;

  i2c_slave_regbank #(.DEV_ADDR(7'h02), .NUM_REGS(16), .REG_AW(4), .DATA_W(8), .FILT_LEN(4)) dut1 (
    .i_ck(clk), .i_rstn(rstn), .SCL(scl), .SDA(sda_bus),
    .reg_addr(addr1), .reg_wr_en(wr1), .reg_wdata(wd1),
    .reg_rd_en(rd1), .reg_rdata(rdata1), .busy(busy1));

  i2c_slave_regbank #(.DEV_ADDR(7'h03), .NUM_REGS(12), .REG_AW(4), .DATA_W(8), .FILT_LEN(4)) dut2 (
    .i_ck(clk), .i_rstn(rstn), .SCL(scl), .SDA(sda_bus),
    .reg_addr(addr2), .reg_wr_en(wr2), .reg_wdata(wd2),
    .reg_rd_en(rd2), .reg_rdata(rdata2), .busy(busy2));

  // Register file behind target 0x02: synchronous write and read
  always @(posedge clk) begin
    if (wr1) mem[addr1] <= wd1;
    if (rd1) rdata1 <= mem[addr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every write strobe is checked against the scoreboard
  always @(negedge clk) begin
    logic [11:0] e;
    if (wr1) begin
      n_wr1++;
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected_strobe", exp_wr.size(), 1);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", {28'd0, addr1}, {20'd0, e[11:8]});
        chk("wr_data", {24'd0, wd1}, {24'd0, e[7:0]});
      end
    end
    if (rd1) n_rd1++;
    if (wr2) n_wr2++;
    if ((wr1 && rd1) || (wr2 && rd2)) n_overlap++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic quarter();
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b1; quarter();
    scl = 1'b0;       quarter();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; quarter();
    scl = 1'b1;       quarter();
    m_sda_low = 1'b0; quarter();
  endtask

  // Send one bit; with g set, flip SDA for 2 clocks in the middle of SCL high
  task automatic send_bit(input logic b, input logic g);
    m_sda_low = ~b; quarter();
    scl = 1'b1;
    repeat (5) @(negedge clk);
    if (g) m_sda_low = b;
    repeat (2) @(negedge clk);
    m_sda_low = ~b;
    repeat (13) @(negedge clk);
    scl = 1'b0; quarter();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; quarter();
    scl = 1'b1;       quarter();
    b = sda_bus;      quarter();
    scl = 1'b0;       quarter();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    for (int k = 7; k >= 0; k--) send_bit(d[k], gmask[k]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         wr_base, rd_base;

    // ---- reset state ----
    repeat (5) @(negedge clk);
    chk("rst_sda", sda_bus, 1'b1);
    chk("rst_addr", addr1, 4'd0);
    chk("rst_wr_en", wr1, 1'b0);
    chk("rst_rd_en", rd1, 1'b0);
    chk("rst_wdata", wd1, 8'h00);
    chk("rst_busy", busy1, 1'b0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // ---- burst write: ptr 3, A5, 5A ----
    i2c_start();
    send_byte(8'h04, 8'h00, ack); chk("t1_ack_addr", ack, 1'b0);
    chk("t1_busy_on", busy1, 1'b1);
    send_byte(8'h03, 8'h00, ack); chk("t1_ack_ptr", ack, 1'b0);
    exp_wr.push_back({4'd3, 8'hA5});
    send_byte(8'hA5, 8'h00, ack); chk("t1_ack_d0", ack, 1'b0);
    exp_wr.push_back({4'd4, 8'h5A});
    send_byte(8'h5A, 8'h00, ack); chk("t1_ack_d1", ack, 1'b0);
    chk("t1_addr_final", addr1, 4'd5);
    chk("t1_busy_before_stop", busy1, 1'b1);
    i2c_stop();
    chk("t1_busy_after_stop", busy1, 1'b0);
    chk("t1_wr_queue_empty", exp_wr.size(), 0);

    // ---- preload 14,15,0 with wrap, then read back via repeated START ----
    i2c_start();
    send_byte(8'h04, 8'h00, ack); chk("t2_ack_addr", ack, 1'b0);
    send_byte(8'h0E, 8'h00, ack); chk("t2_ack_ptr", ack, 1'b0);
    exp_wr.push_back({4'd14, 8'h11}); send_byte(8'h11, 8'h00, ack);
    exp_wr.push_back({4'd15, 8'h22}); send_byte(8'h22, 8'h00, ack);
    exp_wr.push_back({4'd0,  8'h33}); send_byte(8'h33, 8'h00, ack);
    chk("t2_ack_last_wr", ack, 1'b0);
    i2c_stop();
    chk("t2_addr_after_wrap_wr", addr1, 4'd1);
    i2c_start();
    send_byte(8'h04, 8'h00, ack);
    send_byte(8'h0E, 8'h00, ack); chk("t2_ack_ptr2", ack, 1'b0);
    rd_base = n_rd1;
    i2c_start();
    send_byte(8'h05, 8'h00, ack); chk("t2_ack_rd_addr", ack, 1'b0);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    recv_byte(d, 1'b0); chk("t2_rd_byte0", d, exp_rd.pop_front());
    recv_byte(d, 1'b0); chk("t2_rd_byte1", d, exp_rd.pop_front());
    recv_byte(d, 1'b1); chk("t2_rd_byte2", d, exp_rd.pop_front());
    quarter();
    chk("t2_sda_released", sda_bus, 1'b1);
    chk("t2_busy_after_nack", busy1, 1'b0);
    chk("t2_addr_after_nack", addr1, 4'd1);
    chk("t2_rd_strobes", n_rd1 - rd_base, 4);
    i2c_stop();

    // ---- non-matching address 0x0A ----
    wr_base = n_wr1; rd_base = n_rd1;
    i2c_start();
    send_byte(8'h14, 8'h00, ack); chk("t3_nack_addr", ack, 1'b1);
    chk("t3_busy1", busy1, 1'b0);
    chk("t3_busy2", busy2, 1'b0);
    i2c_stop();
    chk("t3_no_wr", n_wr1 - wr_base, 0);
    chk("t3_no_rd", n_rd1 - rd_base, 0);

    // ---- second target (12 regs): legal ptr 5, then ptr 0x0C rejected ----
    i2c_start();
    send_byte(8'h06, 8'h00, ack); chk("t4_ack_addr", ack, 1'b0);
    chk("t4_busy2", busy2, 1'b1);
    chk("t4_busy1_idle", busy1, 1'b0);
    send_byte(8'h05, 8'h00, ack); chk("t4_ack_ptr5", ack, 1'b0);
    i2c_stop();
    chk("t4_addr2_5", addr2, 4'd5);
    i2c_start();
    send_byte(8'h06, 8'h00, ack);
    send_byte(8'h0C, 8'h00, ack); chk("t4_nack_ptr12", ack, 1'b1);
    chk("t4_busy2_after_nack", busy2, 1'b0);
    chk("t4_addr2_kept", addr2, 4'd5);
    send_byte(8'h99, 8'h00, ack); chk("t4_no_ack_after_nack", ack, 1'b1);
    i2c_stop();
    chk("t4_no_wr2", n_wr2, 0);

    // ---- glitches while SCL high, then STOP mid-byte ----
    i2c_start();
    send_byte(8'h04, 8'h00, ack);
    send_byte(8'h07, 8'h00, ack);
    exp_wr.push_back({4'd7, 8'h3C});
    send_byte(8'h3C, 8'h84, ack); chk("t5_ack_glitch_byte", ack, 1'b0);
    chk("t5_busy_kept", busy1, 1'b1);
    i2c_stop();
    chk("t5_wr_queue_empty", exp_wr.size(), 0);
    wr_base = n_wr1;
    i2c_start();
    send_byte(8'h04, 8'h00, ack);
    send_byte(8'h09, 8'h00, ack); chk("t5_ack_ptr9", ack, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    i2c_stop();
    chk("t5_busy_after_midstop", busy1, 1'b0);
    chk("t5_no_partial_write", n_wr1 - wr_base, 0);
    chk("t5_addr_kept", addr1, 4'd9);

    // ---- async reset while target drives SDA low during a read ----
    i2c_start();
    send_byte(8'h04, 8'h00, ack);
    send_byte(8'h00, 8'h00, ack);
    i2c_start();
    send_byte(8'h05, 8'h00, ack); chk("t6_ack_rd_addr", ack, 1'b0);
    chk("t6_sda_driven_low", sda_bus, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_sda", sda_bus, 1'b1);
    chk("t6_rst_busy", busy1, 1'b0);
    chk("t6_rst_addr", addr1, 4'd0);
    chk("t6_rst_rd_en", rd1, 1'b0);
    chk("t6_rst_wr_en", wr1, 1'b0);
    chk("t6_rst_wdata", wd1, 8'h00);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    quarter();
    scl = 1'b1;
    quarter(); quarter();

    // ---- a normal transfer is accepted after reset ----
    i2c_start();
    send_byte(8'h04, 8'h00, ack); chk("t7_ack_addr", ack, 1'b0);
    send_byte(8'h02, 8'h00, ack);
    exp_wr.push_back({4'd2, 8'h77});
    send_byte(8'h77, 8'h00, ack); chk("t7_ack_data", ack, 1'b0);
    i2c_stop();
    chk("t7_addr", addr1, 4'd3);
    chk("t7_wr_queue_empty", exp_wr.size(), 0);
    chk("no_wr_rd_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
